f51m_bist_ctrl: RTL and testbench
=================================

Name: f51m_bist_ctrl

Overview:
Self-test driver and response compactor for the f51m_comb combinational block, sitting on the opposite side of its 8-in/8-out pad interface.
- Drives the 8 DUT inputs (\1_pad..\8_pad) with an exhaustive binary pattern sequence.
- Compacts the 8 DUT outputs (\44_pad..\51_pad) into an 8-bit MISR signature.
- Reports done and pass/fail against a golden signature.
- Used for post-mapping equivalence smoke checks of mapped netlists on silicon or emulation.

Parameters:
NUM_PATTERNS, 256, number of patterns applied (1..256); pattern value = index 0..NUM_PATTERNS-1.
RSP_LAT, 0, pipeline cycles between pat_pad change and rsp_pad valid (0..3).
MISR_POLY, 8'h1D, MISR feedback taps, applied when sig[7]=1 before the shift.
GOLDEN, 8'h00, expected final signature.

Ports:
clk_pad  in  1  clock; all state on rising edge
rst_n_pad  in  1  reset, asynchronous, active-low
start_pad  in  1  start request, sampled in IDLE or DONE only
pat_pad  out  8  registered pattern to DUT inputs; bit0 -> \1_pad ... bit7 -> \8_pad
rsp_pad  in  8  DUT response; bit0 <- \44_pad ... bit7 <- \51_pad
busy_pad  out  1  high in RUN and FLUSH
done_pad  out  1  high in DONE; held until next start or reset
sig_pad  out  8  current MISR value
pass_pad  out  1  in DONE: sig==GOLDEN; 0 in all other states

Behaviour:
Interface and reset:
- One clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, pat_pad=0, sig_pad=0, busy_pad=0, done_pad=0, pass_pad=0, pattern counter=0, capture pipeline cleared.

States:
- IDLE: start_pad=1 -> RUN; clear sig, counter and pipeline; pat_pad=0 on entry.
- RUN: each cycle pat_pad=counter, then counter+1. After the cycle presenting NUM_PATTERNS-1 -> FLUSH, or -> DONE directly if RSP_LAT=0.
- FLUSH: lasts RSP_LAT cycles; pat_pad holds its last value; captures drain.
- DONE: done_pad=1 and pass_pad valid. start_pad=1 -> RUN with sig cleared, same as from IDLE.

Capture:
- A valid-tagged shift pipeline of depth RSP_LAT marks which cycles carry a real response.
- rsp_pad is folded into the MISR exactly NUM_PATTERNS times, once per valid tag.
- With RSP_LAT=0, rsp_pad is folded in the same cycle its pat_pad is presented. Pat is registered and the DUT is combinational, so rsp is valid that cycle.

MISR update, 8-bit, wraps modulo 2^8:
- sig <= {sig[6:0],1'b0} ^ (sig[7] ? MISR_POLY : 8'h00) ^ rsp_pad.

Counter:
- 9-bit, so NUM_PATTERNS=256 terminates without wrap ambiguity.
- pat_pad = counter[7:0].

Boundary conditions:
- start_pad during RUN/FLUSH is ignored; no restart, no effect on sig.
- start_pad held high continuously: one run per entry to DONE. DONE lasts at least 1 cycle before restarting.
- NUM_PATTERNS=1: one pattern (0x00), one capture.
- Reset asserted mid-run: all outputs return to reset values asynchronously. No run resumes after release until a new start_pad.
- pass_pad is only driven from the DONE state; it is never 1 while busy.

Total latency, start accepted to done_pad=1: 1 + NUM_PATTERNS + RSP_LAT cycles.

Optional Feature:
F51M_BIST_ABORT_EN:
- Defined: adds input abort_pad (1 bit). abort_pad=1 in RUN or FLUSH -> DONE next cycle with pass_pad forced 0 and an extra output aborted_pad=1. aborted_pad clears on the next start or on reset. abort_pad is ignored in IDLE and DONE.
- Undefined: no abort_pad or aborted_pad ports; a run always completes.

Test Plan:
- Reset, then start pulse, rsp_pad tied 0x00, NUM_PATTERNS=256, GOLDEN=0x00 -> pat_pad steps 0x00..0xFF one per cycle; done_pad rises 257 cycles after start; sig_pad=0x00; pass_pad=1.
- NUM_PATTERNS=1, rsp_pad=0xA5 -> sig_pad=0xA5, done after 2 cycles; pass_pad=0 with GOLDEN=0x00.
- NUM_PATTERNS=2, rsp_pad constant 0x01 -> sig_pad=0x03. With rsp_pad constant 0x80 -> sig_pad=0x9D (exercises the feedback path).
- RSP_LAT=2, NUM_PATTERNS=2, rsp_pad=0x01, but rsp_pad forced to 0xFF during the 2 cycles before valid data -> sig_pad=0x03. Done at 1+2+2=5 cycles; busy_pad high for 4 cycles.
- start_pad pulsed at pattern 0x40 mid-run -> no restart, final sig unchanged. Reset asserted at pattern 0x80 -> pat_pad, sig_pad, busy_pad and done_pad all read 0 immediately; IDLE holds until the next start.
- F51M_BIST_ABORT_EN defined, abort_pad pulsed at pattern 0x10 -> next cycle done_pad=1, aborted_pad=1, pass_pad=0. A subsequent start clears aborted_pad and runs the full sequence.

Source files
------------

// File: rtl/f51m_bist_ctrl.sv
// ---------------------------------------------------------------------------
// f51m_bist_ctrl
// Self-test driver and response compactor for the f51m_comb block. Applies
// patterns 0..NUM_PATTERNS-1 to the block's 8 inputs and folds its 8 outputs
// into an 8-bit MISR. At the end it reports done and pass/fail against GOLDEN.
//
// Ports:
//   clk_pad     in   1  clock, rising edge
//   rst_n_pad   in   1  asynchronous active-low reset
//   start_pad   in   1  start request (honoured in IDLE or DONE only)
//   pat_pad     out  8  registered pattern to the block under test
//   rsp_pad     in   8  response from the block under test
//   busy_pad    out  1  high while patterns are applied or captures drain
//   done_pad    out  1  high in DONE until next start or reset
//   sig_pad     out  8  current MISR signature
//   pass_pad    out  1  signature matched GOLDEN (DONE only)
//   abort_pad   in   1  (F51M_BIST_ABORT_EN only) stop the run early
//   aborted_pad out  1  (F51M_BIST_ABORT_EN only) last run was aborted
//
// Optional feature macro: F51M_BIST_ABORT_EN
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module f51m_bist_ctrl #(
    parameter int unsigned NUM_PATTERNS = 256,
    parameter int unsigned RSP_LAT      = 0,
    parameter logic [7:0]  MISR_POLY    = 8'h1D,
    parameter logic [7:0]  GOLDEN       = 8'h00
) (
    input  logic       clk_pad,
    input  logic       rst_n_pad,
    input  logic       start_pad,
    output logic [7:0] pat_pad,
    input  logic [7:0] rsp_pad,
    output logic       busy_pad,
    output logic       done_pad,
    output logic [7:0] sig_pad,
    output logic       pass_pad
`ifdef F51M_BIST_ABORT_EN
    ,
    input  logic       abort_pad,
    output logic       aborted_pad
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    // r_cnt holds the index of the NEXT pattern; it equals NUM_PATTERNS while
    // the final pattern is on pat_pad. 9 bits so 256 is representable.
    localparam logic [8:0] LAST_CNT   = 9'(NUM_PATTERNS);
    localparam logic [1:0] FLUSH_LAST = 2'((RSP_LAT == 0) ? 0 : RSP_LAT - 1);

    state_t     r_state;
    logic [8:0] r_cnt;
    logic [1:0] r_flush_cnt;
    logic [7:0] r_pat;
    logic [7:0] r_sig;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
`ifdef F51M_BIST_ABORT_EN
    logic       r_aborted;
`endif

    logic       w_start;
    logic       w_active;
    logic       w_abort;
    logic       w_tag;
    logic       w_fold;
    logic [7:0] w_sig_next;
    logic [7:0] w_sig_final;

    assign w_start  = start_pad && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_active = (r_state == S_RUN) || (r_state == S_FLUSH);

`ifdef F51M_BIST_ABORT_EN
    assign w_abort = abort_pad && w_active;
`else
    assign w_abort = 1'b0;
`endif

    // Valid tags: every RUN cycle presents a real pattern; its response is
    // valid RSP_LAT cycles later, so the tag travels down a shift chain.
    generate
        if (RSP_LAT == 0) begin : g_no_pipe
            assign w_tag = (r_state == S_RUN);
        end else begin : g_pipe
            logic [RSP_LAT-1:0] r_vld;
            logic [RSP_LAT:0]   w_chain;

            assign w_chain = {r_vld, (r_state == S_RUN)};
            assign w_tag   = w_chain[RSP_LAT];

            always_ff @(posedge clk_pad or negedge rst_n_pad) begin
                if (!rst_n_pad) begin
                    r_vld <= '0;
                end else if (w_start || w_abort) begin
                    r_vld <= '0;
                end else begin
                    r_vld <= w_chain[RSP_LAT-1:0];
                end
            end
        end
    endgenerate

    assign w_fold      = w_tag && w_active;
    assign w_sig_next  = {r_sig[6:0], 1'b0} ^ (r_sig[7] ? MISR_POLY : 8'h00) ^ rsp_pad;
    assign w_sig_final = w_fold ? w_sig_next : r_sig;

    always_ff @(posedge clk_pad or negedge rst_n_pad) begin
        if (!rst_n_pad) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_flush_cnt <= '0;
            r_pat       <= '0;
            r_sig       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
`ifdef F51M_BIST_ABORT_EN
            r_aborted   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start) begin
                        r_state <= S_RUN;
                        r_pat   <= 8'h00;
                        r_cnt   <= 9'd1;
                        r_sig   <= 8'h00;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
`ifdef F51M_BIST_ABORT_EN
                        r_aborted <= 1'b0;
`endif
                    end
                end
                S_RUN: begin
                    r_sig <= w_sig_final;
                    if (w_abort) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= 1'b0;
`ifdef F51M_BIST_ABORT_EN
                        r_aborted <= 1'b1;
`endif
                    end else if (r_cnt == LAST_CNT) begin
                        // Last pattern is on pat_pad; pat_pad holds from here on.
                        if (RSP_LAT == 0) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_sig_final == GOLDEN);
                        end else begin
                            r_state     <= S_FLUSH;
                            r_flush_cnt <= 2'd0;
                        end
                    end else begin
                        r_pat <= r_cnt[7:0];
                        r_cnt <= r_cnt + 9'd1;
                    end
                end
                S_FLUSH: begin
                    r_sig <= w_sig_final;
                    if (w_abort) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= 1'b0;
`ifdef F51M_BIST_ABORT_EN
                        r_aborted <= 1'b1;
`endif
                    end else if (r_flush_cnt == FLUSH_LAST) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_sig_final == GOLDEN);
                    end else begin
                        r_flush_cnt <= r_flush_cnt + 2'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign pat_pad  = r_pat;
    assign sig_pad  = r_sig;
    assign busy_pad = r_busy;
    assign done_pad = r_done;
    assign pass_pad = r_pass;
`ifdef F51M_BIST_ABORT_EN
    assign aborted_pad = r_aborted;
`endif

endmodule

// File: tb/tb_f51m_bist_ctrl.sv
`timescale 1ns/1ps

module tb_f51m_bist_ctrl;

    localparam int NI = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n = 1'b0;
    logic [NI-1:0]     start_v = '0;
    logic [NI-1:0]     busy_v, done_v, pass_v;
    logic [8*NI-1:0]   pat_v, rsp_v, sig_v;
`ifdef F51M_BIST_ABORT_EN
    logic [NI-1:0]     abort_v = '0;
    logic [NI-1:0]     aborted_v;
`endif

    // Stand-in for the combinational block under test: a lookup table.
    logic [7:0] lut [256];

    int checks = 0;
    int errors = 0;

    function automatic int np_of(input int i);
        case (i)
            0: return 256;
            1: return 1;
            2: return 2;
            3: return 2;
            default: return 37;
        endcase
    endfunction
    function automatic int lat_of(input int i);
        case (i)
            3: return 2;
            4: return 3;
            default: return 0;
        endcase
    endfunction
    function automatic logic [7:0] poly_of(input int i);
        return (i == 4) ? 8'hB8 : 8'h1D;
    endfunction
    function automatic logic [7:0] gold_of(input int i);
        return (i == 4) ? 8'h5A : 8'h00;
    endfunction

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            localparam int NP  = (gi == 0) ? 256 : (gi == 1) ? 1 : (gi == 2) ? 2 : (gi == 3) ? 2 : 37;
            localparam int LAT = (gi == 3) ? 2 : (gi == 4) ? 3 : 0;
            localparam logic [7:0] POLY = (gi == 4) ? 8'hB8 : 8'h1D;
            localparam logic [7:0] GOLD = (gi == 4) ? 8'h5A : 8'h00;

            // Response model: lut of the pattern presented LAT cycles ago;
            // during the first LAT cycles of a run the bus carries junk (0xFF).
            logic [7:0] h1 = '0, h2 = '0, h3 = '0;
            int cyc = 0;
            always @(posedge clk) begin
                h1  <= pat_v[gi*8 +: 8];
                h2  <= h1;
                h3  <= h2;
                cyc <= busy_v[gi] ? cyc + 1 : 0;
            end
            assign rsp_v[gi*8 +: 8] = (LAT != 0 && cyc < LAT) ? 8'hFF :
                                      lut[(LAT == 0) ? pat_v[gi*8 +: 8] :
                                          (LAT == 1) ? h1 : (LAT == 2) ? h2 : h3];

            f51m_bist_ctrl #(
                .NUM_PATTERNS(NP),
                .RSP_LAT     (LAT),
                .MISR_POLY   (POLY),
                .GOLDEN      (GOLD)
            ) u_dut (
                .clk_pad    (clk),
                .rst_n_pad  (rst_n),
                .start_pad  (start_v[gi]),
                .pat_pad    (pat_v[gi*8 +: 8]),
                .rsp_pad    (rsp_v[gi*8 +: 8]),
                .busy_pad   (busy_v[gi]),
                .done_pad   (done_v[gi]),
                .sig_pad    (sig_v[gi*8 +: 8]),
                .pass_pad   (pass_v[gi])
`ifdef F51M_BIST_ABORT_EN
                ,
                .abort_pad  (abort_v[gi]),
                .aborted_pad(aborted_v[gi])
`endif
            );
        end
    endgenerate

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: signature = polynomial fold of responses 0..n-1, i.e.
    // repeated multiply-by-x in GF(2^8) followed by adding the response.
    function automatic logic [7:0] ref_sig(input int n, input logic [7:0] poly);
        logic [7:0] s;
        s = 8'h00;
        for (int k = 0; k < n; k++) begin
            s = (s[7] ? ((s << 1) ^ poly) : (s << 1)) ^ lut[k];
        end
        return s;
    endfunction

    task automatic fill_lut(input bit rnd, input logic [7:0] cval);
        for (int k = 0; k < 256; k++) lut[k] = rnd ? 8'($urandom) : cval;
    endtask

    // One complete run on instance i. Optionally pokes start when pat_pad
    // shows poke_pat mid-run (must be ignored).
    task automatic run(input int i, input int poke_pat,
                       output logic [7:0] sig, output logic pass, output int lat,
                       output int busy_n, output int pat_err, output int pass_busy);
        int n, cnt, k, e;
        n = np_of(i);
        cnt = 0; busy_n = 0; pat_err = 0; pass_busy = 0;
        @(negedge clk);
        start_v[i] = 1'b1;
        while (cnt < 2000) begin
            @(posedge clk);
            #1;
            cnt++;
            start_v[i] = 1'b0;
            if (busy_v[i]) begin
                busy_n++;
                k = cnt - 1;
                e = (k < n) ? k : n - 1;
                if (pat_v[i*8 +: 8] != 8'(e)) pat_err++;
                if (pass_v[i]) pass_busy++;
                if (poke_pat >= 0 && pat_v[i*8 +: 8] == 8'(poke_pat)) start_v[i] = 1'b1;
            end
            if (done_v[i]) break;
        end
        start_v[i] = 1'b0;
        lat  = cnt;
        sig  = sig_v[i*8 +: 8];
        pass = pass_v[i];
    endtask

    typedef struct {
        int         inst;
        bit         rnd;
        logic [7:0] cval;
        int         poke;
        logic [7:0] exp_sig;
        logic       exp_pass;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        logic [7:0] sig, esig;
        logic pass, epass;
        int lat, busy_n, pat_err, pass_busy, i, n, cnt_d, cnt_b;
        bit found;

        vecs[0] = '{0, 1'b0, 8'h00, -1,   8'h00, 1'b1};
        vecs[1] = '{1, 1'b0, 8'hA5, -1,   8'hA5, 1'b0};
        vecs[2] = '{2, 1'b0, 8'h01, -1,   8'h03, 1'b0};
        vecs[3] = '{2, 1'b0, 8'h80, -1,   8'h9D, 1'b0};
        vecs[4] = '{3, 1'b0, 8'h01, -1,   8'h03, 1'b0};
        vecs[5] = '{0, 1'b1, 8'h00, 8'h40, 8'h00, 1'b0};
        vecs[6] = '{4, 1'b1, 8'h00, -1,   8'h00, 1'b0};
        vecs[7] = '{3, 1'b1, 8'h00, -1,   8'h00, 1'b0};
        vecs[8] = '{1, 1'b1, 8'h00, -1,   8'h00, 1'b0};
        vecs[9] = '{4, 1'b1, 8'h00, 5,    8'h00, 1'b0};

        fill_lut(1'b0, 8'h00);

        // Reset state
        #23;
        chk("rst_pat",  pat_v,  '0);
        chk("rst_sig",  sig_v,  '0);
        chk("rst_busy", busy_v, '0);
        chk("rst_done", done_v, '0);
        chk("rst_pass", pass_v, '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven runs
        for (int v = 0; v < 10; v++) begin
            i = vecs[v].inst;
            n = np_of(i);
            fill_lut(vecs[v].rnd, vecs[v].cval);
            if (vecs[v].rnd) begin
                esig  = ref_sig(n, poly_of(i));
                epass = (esig == gold_of(i));
            end else begin
                esig  = vecs[v].exp_sig;
                epass = vecs[v].exp_pass;
            end
            run(i, vecs[v].poke, sig, pass, lat, busy_n, pat_err, pass_busy);
            $display("run %0d inst=%0d sig=%02h exp=%02h pass=%0b lat=%0d", v, i, sig, esig, pass, lat);
            chk("sig",       sig,       esig);
            chk("pass",      pass,      epass);
            chk("latency",   lat,       1 + n + lat_of(i));
            chk("busy_len",  busy_n,    n + lat_of(i));
            chk("pat_seq",   pat_err,   0);
            chk("pass_busy", pass_busy, 0);
            @(posedge clk); #1;
            chk("done_hold", done_v[i], 1'b1);
        end

        // Reset asserted mid-run at pattern 0x80
        fill_lut(1'b1, 8'h00);
        @(negedge clk);
        start_v[0] = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 400 && !found; c++) begin
            @(posedge clk); #1;
            start_v[0] = 1'b0;
            if (busy_v[0] && pat_v[7:0] == 8'h80) found = 1'b1;
        end
        chk("rst_reach", found, 1'b1);
        rst_n = 1'b0;
        #1;
        $display("midrun reset pat=%02h sig=%02h busy=%0b done=%0b", pat_v[7:0], sig_v[7:0], busy_v[0], done_v[0]);
        chk("mid_rst_pat",  pat_v[7:0], 8'h00);
        chk("mid_rst_sig",  sig_v[7:0], 8'h00);
        chk("mid_rst_busy", busy_v[0],  1'b0);
        chk("mid_rst_done", done_v[0],  1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_busy", busy_v[0],  1'b0);
        chk("idle_done", done_v[0],  1'b0);
        chk("idle_pat",  pat_v[7:0], 8'h00);

        // start held high on the single-pattern instance: RUN/DONE alternate
        fill_lut(1'b0, 8'h3C);
        @(negedge clk);
        start_v[1] = 1'b1;
        cnt_d = 0; cnt_b = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (done_v[1]) cnt_d++;
            if (busy_v[1]) cnt_b++;
        end
        start_v[1] = 1'b0;
        $display("held start done_cycles=%0d busy_cycles=%0d", cnt_d, cnt_b);
        chk("held_done_cycles", cnt_d, 6);
        chk("held_busy_cycles", cnt_b, 6);
        repeat (2) @(posedge clk);
        #1;
        chk("held_sig", sig_v[15:8], 8'h3C);

`ifdef F51M_BIST_ABORT_EN
        // Abort at pattern 0x10, then a clean full run
        fill_lut(1'b1, 8'h00);
        @(negedge clk);
        start_v[0] = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 400 && !found; c++) begin
            @(posedge clk); #1;
            start_v[0] = 1'b0;
            if (busy_v[0] && pat_v[7:0] == 8'h10) found = 1'b1;
        end
        chk("abort_reach", found, 1'b1);
        abort_v[0] = 1'b1;
        @(posedge clk); #1;
        abort_v[0] = 1'b0;
        $display("abort done=%0b aborted=%0b pass=%0b", done_v[0], aborted_v[0], pass_v[0]);
        chk("abort_done",    done_v[0],    1'b1);
        chk("abort_flag",    aborted_v[0], 1'b1);
        chk("abort_pass",    pass_v[0],    1'b0);
        chk("abort_busy",    busy_v[0],    1'b0);
        esig = ref_sig(256, 8'h1D);
        run(0, -1, sig, pass, lat, busy_n, pat_err, pass_busy);
        $display("post-abort run sig=%02h exp=%02h lat=%0d", sig, esig, lat);
        chk("post_abort_flag", aborted_v[0], 1'b0);
        chk("post_abort_sig",  sig,          esig);
        chk("post_abort_lat",  lat,          257);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
